// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the ASCII host bridge (bridge_tx / bridge_rx).
//   - ASCII framing constants used by both directions of the bridge.
//   - to_hex_ascii(): 4-bit nibble -> uppercase ASCII hex character.
//   - tx_state_t: message-serialiser state encoding for bridge_tx.
// -----------------------------------------------------------------------------
package bridge_pkg;

  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    NIBBLE,
    CR,
    LF
  } tx_state_t;

  // 0-9 -> '0'-'9' (0x30..0x39), A-F -> 'A'-'F' (0x41..0x46).
  // 0x37 + 10 = 0x41, so the letter range is a single offset add.
  function automatic logic [7:0] to_hex_ascii(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    else                return 8'h37 + {4'h0, nibble};
  endfunction

endpackage

// File: rtl/bridge_tx.sv
// -----------------------------------------------------------------------------
// bridge_tx
// Outbound half of the ASCII host bridge. A read response from the bus side
// is latched and serialised as 'M', DATA_WIDTH/4 uppercase hex nibbles
// (MSB first), CR, LF, one byte per valid_o/ready_i handshake.
// Write responses (rw_i = 1) are ignored. A read response that arrives while
// a message is in flight is discarded and flagged on drop_o for one cycle.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   data_i   in   [DATA_WIDTH] read-response data
//   rw_i     in   0 = read response (transmit), 1 = write (ignore)
//   valid_i  in   response strobe
//   ready_o  out  high while idle (next read response will be accepted)
//   drop_o   out  one-cycle pulse: busy, read response discarded
//   data_o   out  [8] ASCII byte to the UART transmitter
//   valid_o  out  data_o valid
//   ready_i  in   UART transmitter accepts data_o when valid_o && ready_i
// -----------------------------------------------------------------------------
module bridge_tx
  import bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 16  // must be a multiple of 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  drop_o,
  output logic [7:0]            data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int N     = DATA_WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  tx_state_t             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [7:0]            data_d;
  logic                  valid_d;
  logic                  drop_d;
  logic                  handshake;
  logic                  read_req;

  // Nibble i of the buffer, i = 0 is the least significant.
  function automatic logic [3:0] nibble_at(input logic [DATA_WIDTH-1:0] b,
                                           input logic [IDX_W-1:0]      i);
    return 4'(b >> {i, 2'b00});
  endfunction

  assign handshake = valid_o && ready_i;
  assign read_req  = valid_i && !rw_i;

  // Decoded from the state register only, so no input reaches it combinationally.
  assign ready_o = (state_q == IDLE);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    data_d  = data_o;
    valid_d = valid_o;
    drop_d  = read_req && (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (read_req) begin
          buf_d   = data_i;
          state_d = HEADER;
          data_d  = ASCII_M;
          valid_d = 1'b1;
        end
      end
      HEADER: begin
        if (handshake) begin
          state_d = NIBBLE;
          idx_d   = IDX_TOP;
          data_d  = to_hex_ascii(nibble_at(buf_q, IDX_TOP));
        end
      end
      NIBBLE: begin
        if (handshake) begin
          if (idx_q == '0) begin
            state_d = CR;
            data_d  = ASCII_CR;
          end else begin
            idx_d  = idx_q - 1'b1;
            data_d = to_hex_ascii(nibble_at(buf_q, idx_q - 1'b1));
          end
        end
      end
      CR: begin
        if (handshake) begin
          state_d = LF;
          data_d  = ASCII_LF;
        end
      end
      LF: begin
        if (handshake) begin
          state_d = IDLE;
          data_d  = 8'h00;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = 8'h00;
        valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      data_o  <= 8'h00;
      valid_o <= 1'b0;
      drop_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      data_o  <= data_d;
      valid_o <= valid_d;
      drop_o  <= drop_d;
    end
  end

endmodule

// File: tb/tb_bridge_tx.sv
// -----------------------------------------------------------------------------
// tb_bridge_tx
// Directed testbench for bridge_tx (DATA_WIDTH = 16). Inputs change 1 time
// unit after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_bridge_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_i;
  logic        rw_i;
  logic        valid_i;
  logic        ready_o;
  logic        drop_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int         vcyc;
  int         ready_bad;
  int         drop_cnt;
  int         hold_bad;
  int         first_k;
  bit         done;

  bridge_tx #(.DATA_WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .rw_i    (rw_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .drop_o  (drop_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=%0t required<200000", $time);
    $fatal(1);
  end

  // Present one read response for a single edge; returns 1 unit after that edge.
  task automatic send(input logic [15:0] d);
    @(posedge clk); #1;
    data_i  = d;
    rw_i    = 1'b0;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Record the bytes handed over on handshakes until valid_o falls.
  // toggle: ready_i follows 1,0,0,1,0,0,... ; inject_at: cycle at which a
  // read response is presented while busy (-1 for none).
  task automatic capture(input int budget, input bit toggle,
                         input int inject_at, input logic [15:0] inject_data);
    logic [7:0] prev_data  = 8'h00;
    bit         prev_stall = 1'b0;
    bit         seen       = 1'b0;
    got.delete();
    vcyc = 0; ready_bad = 0; drop_cnt = 0; hold_bad = 0; first_k = -1; done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      ready_i = toggle ? (k % 3 == 0) : 1'b1;
      if (k == inject_at) begin
        valid_i = 1'b1; rw_i = 1'b0; data_i = inject_data;
      end else begin
        valid_i = 1'b0;
      end
      if (drop_o) drop_cnt++;
      if (valid_o) begin
        if (!seen) first_k = k;
        seen = 1'b1;
        vcyc++;
        if (ready_o) ready_bad++;
        if (prev_stall && data_o !== prev_data) hold_bad++;
        if (ready_i) got.push_back(data_o);
        prev_stall = !ready_i;
        prev_data  = data_o;
      end else begin
        if (prev_stall) hold_bad++;
        if (seen) begin
          done = 1'b1;
          break;
        end
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; data_i = '0; rw_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    #12;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    checks++;
    if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", data_o); end
    checks++;
    if (drop_o !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b required 0", drop_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready_o); end
  endtask

  task automatic test_basic;
    logic [7:0] exp [7];
    logic [7:0] act;
    exp = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    send(16'h1234);
    capture(30, 1'b0, -1, 16'h0);
    checks++;
    if (got.size() != 7 || !done) begin errors++; $display("FAIL basic_len: got %0d bytes done=%0b required 7 done=1", got.size(), done); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp[i]) begin errors++; $display("FAIL basic_byte%0d: got %h required %h", i, act, exp[i]); end
    end
    checks++;
    if (vcyc != 7 || first_k != 0) begin errors++; $display("FAIL basic_cycles: got %0d valid cycles from %0d required 7 from 0", vcyc, first_k); end
    checks++;
    if (ready_bad != 0) begin errors++; $display("FAIL basic_ready_busy: got %0d cycles high required 0", ready_bad); end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL basic_ready_after: got %b required 1", ready_o); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp1 [7];
    logic [7:0] exp2 [7];
    logic [7:0] act;
    int         drops;
    exp1 = '{8'h4D, 8'h44, 8'h45, 8'h41, 8'h44, 8'h0D, 8'h0A};
    exp2 = '{8'h4D, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    send(16'hDEAD);
    capture(30, 1'b0, -1, 16'h0);
    drops = drop_cnt;
    checks++;
    if (got.size() != 7 || !done) begin errors++; $display("FAIL b2b_len1: got %0d bytes done=%0b required 7 done=1", got.size(), done); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp1[i]) begin errors++; $display("FAIL b2b_dead_byte%0d: got %h required %h", i, act, exp1[i]); end
    end
    // This is the single idle cycle after the LF handshake.
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL b2b_gap: got ready=%b valid=%b required ready=1 valid=0", ready_o, valid_o); end
    data_i = 16'hBEEF; rw_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    capture(30, 1'b0, -1, 16'h0);
    drops += drop_cnt;
    checks++;
    if (got.size() != 7 || !done || first_k != 0) begin errors++; $display("FAIL b2b_len2: got %0d bytes done=%0b first=%0d required 7 done=1 first=0", got.size(), done, first_k); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp2[i]) begin errors++; $display("FAIL b2b_beef_byte%0d: got %h required %h", i, act, exp2[i]); end
    end
    checks++;
    if (drops != 0) begin errors++; $display("FAIL b2b_drop: got %0d pulses required 0", drops); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp [7];
    logic [7:0] act;
    exp = '{8'h4D, 8'h43, 8'h41, 8'h46, 8'h45, 8'h0D, 8'h0A};
    send(16'hCAFE);
    capture(60, 1'b1, -1, 16'h0);
    checks++;
    if (got.size() != 7 || !done) begin errors++; $display("FAIL bp_len: got %0d bytes done=%0b required 7 done=1", got.size(), done); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, act, exp[i]); end
    end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable stalls required 0", hold_bad); end
    // Byte i is taken on cycle 3*i, so the last one lands on cycle 18.
    checks++;
    if (vcyc != 19) begin errors++; $display("FAIL bp_cycles: got %0d valid cycles required 19", vcyc); end
  endtask

  task automatic test_write_ignored;
    int valid_seen = 0;
    int drop_seen  = 0;
    @(posedge clk); #1;
    data_i = 16'h5678; rw_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k == 3) valid_i = 1'b0;
      @(posedge clk); #1;
      if (valid_o) valid_seen++;
      if (drop_o) drop_seen++;
    end
    rw_i = 1'b0;
    checks++;
    if (valid_seen != 0) begin errors++; $display("FAIL write_valid: got %0d cycles high required 0", valid_seen); end
    checks++;
    if (drop_seen != 0) begin errors++; $display("FAIL write_drop: got %0d cycles high required 0", drop_seen); end
  endtask

  task automatic test_busy_drop;
    logic [7:0] exp [7];
    logic [7:0] act;
    exp = '{8'h4D, 8'h30, 8'h46, 8'h30, 8'h46, 8'h0D, 8'h0A};
    send(16'h0F0F);
    capture(30, 1'b0, 2, 16'h1111);
    checks++;
    if (drop_cnt != 1) begin errors++; $display("FAIL drop_pulse: got %0d cycles required 1", drop_cnt); end
    checks++;
    if (got.size() != 7 || !done) begin errors++; $display("FAIL drop_len: got %0d bytes done=%0b required 7 done=1", got.size(), done); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp[i]) begin errors++; $display("FAIL drop_byte%0d: got %h required %h", i, act, exp[i]); end
    end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL drop_no_second_msg: got valid %b required 0", valid_o); end
  endtask

  task automatic test_lf_edge_drop;
    // Read presented on the LF handshake edge (cycle 6) is dropped.
    send(16'h2468);
    capture(30, 1'b0, 6, 16'h9999);
    checks++;
    if (drop_cnt != 1) begin errors++; $display("FAIL lf_drop_pulse: got %0d cycles required 1", drop_cnt); end
    checks++;
    if (got.size() != 7 || got[6] !== 8'h0A) begin errors++; $display("FAIL lf_drop_msg: got %0d bytes required 7 ending 0a", got.size()); end
    @(posedge clk); #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL lf_drop_idle: got valid=%b ready=%b required valid=0 ready=1", valid_o, ready_o); end
  endtask

  task automatic test_reset_mid_message;
    logic [7:0] exp [7];
    logic [7:0] act;
    exp = '{8'h4D, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    ready_i = 1'b1;
    send(16'hABCD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (data_o !== 8'h42) begin errors++; $display("FAIL rst_pre_byte: got %h required 42", data_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || data_o !== 8'h00) begin errors++; $display("FAIL rst_async: got valid=%b data=%h required valid=0 data=00", valid_o, data_o); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL rst_idle: got ready=%b valid=%b required ready=1 valid=0", ready_o, valid_o); end
    send(16'h0001);
    capture(30, 1'b0, -1, 16'h0);
    checks++;
    if (got.size() != 7 || !done) begin errors++; $display("FAIL rst_len: got %0d bytes done=%0b required 7 done=1", got.size(), done); end
    for (int i = 0; i < 7; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      checks++;
      if (act !== exp[i]) begin errors++; $display("FAIL rst_byte%0d: got %h required %h", i, act, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_write_ignored();
    test_busy_drop();
    test_lf_edge_drop();
    test_reset_mid_message();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
